vga_sync_capture: RTL and testbench

Receive-side counterpart of the 640x480 VGA output path: consumes hsync/vsync/12-bit RGB from a VGA-timed source, recovers pixel coordinates, checks timing lock, and writes a rectangular window of pixels into a logo-sized memory through a simple write port. It sits in the pixel-clock domain, driven by the 25 MHz DCM output. It fills the image RAM that the display path later reads.

---
 rtl/vga_cap_pkg.sv | 24 ++
 rtl/vga_sync_meter.sv | 130 +++++++++++++
 rtl/vga_sync_capture.sv | 199 +++++++++++++++++++
 tb/tb_vga_sync_capture.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_cap_pkg.sv
// Shared constants and state encodings for the VGA capture path.
// 640x480 @ 25 MHz timing; module parameters default to these values.
package vga_cap_pkg;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_START  = 144;
    localparam int VGA_V_START  = 35;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_CHECK    = 2'd1,
        LK_LOCKED   = 2'd2
    } lock_state_t;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2
    } cap_state_t;

endpackage

// File: rtl/vga_sync_meter.sv
// Input registers, sync edge detection, position counters and timing-lock FSM.
// x/y/active/pix are aligned to one another: all describe the pixel held in the S1 register.
module vga_sync_meter
    import vga_cap_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_START     = VGA_H_START,
    parameter int V_START     = VGA_V_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output lock_state_t lock_state,
    output logic        vs_fall,
    output logic        active,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [11:0] pix
);

    localparam logic [10:0] H_TOT11 = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT10 = 10'(V_TOTAL);
    localparam logic [10:0] H_BEG11 = 11'(H_START);
    localparam logic [10:0] H_END11 = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  H_BEG10 = 10'(H_START);
    localparam logic [9:0]  V_BEG10 = 10'(V_START);
    localparam logic [9:0]  V_END10 = 10'(V_START + V_ACTIVE);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

    logic        hs1_q, hs2_q, vs1_q, vs2_q;
    logic [11:0] rgb1_q;
    logic [10:0] h_pos_q, h_pos_d;
    logic [9:0]  line_q, line_d;
    lock_state_t lock_q, lock_d;
    logic [3:0]  good_q, good_d;
    logic        hs_fall, line_bad, frame_bad;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hs1_q   <= 1'b0;
            hs2_q   <= 1'b0;
            vs1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            rgb1_q  <= '0;
            h_pos_q <= '0;
            line_q  <= '0;
            lock_q  <= LK_UNLOCKED;
            good_q  <= '0;
        end else begin
            hs1_q   <= hsync_in;
            hs2_q   <= hs1_q;
            vs1_q   <= vsync_in;
            vs2_q   <= vs1_q;
            rgb1_q  <= rgb_in;
            h_pos_q <= h_pos_d;
            line_q  <= line_d;
            lock_q  <= lock_d;
            good_q  <= good_d;
        end
    end

    assign hs_fall = hs2_q & ~hs1_q;
    assign vs_fall = vs2_q & ~vs1_q;

    // The *_d values are the coordinates of the pixel currently in rgb1_q.
    always_comb begin
        h_pos_d = h_pos_q;
        if (hs_fall)
            h_pos_d = '0;
        else if (h_pos_q != 11'h7FF)
            h_pos_d = h_pos_q + 11'd1;
        line_d = line_q;
        if (vs_fall)
            line_d = '0;
        else if (hs_fall && line_q != 10'h3FF)
            line_d = line_q + 10'd1;
    end

    assign active = (h_pos_d >= H_BEG11) && (h_pos_d < H_END11) &&
                    (line_d >= V_BEG10) && (line_d < V_END10);
    assign x   = h_pos_d[9:0] - H_BEG10;
    assign y   = line_d - V_BEG10;
    assign pix = rgb1_q;

    assign line_bad  = hs_fall && ((h_pos_q + 11'd1) != H_TOT11);
    assign frame_bad = vs_fall && ((line_q + 10'd1) != V_TOT10);

    // Measurements taken while unlocked are meaningless; the first vsync only opens the window.
    always_comb begin
        lock_d = lock_q;
        good_d = good_q;
        case (lock_q)
            LK_UNLOCKED: begin
                if (vs_fall) begin
                    lock_d = LK_CHECK;
                    good_d = '0;
                end
            end
            LK_CHECK: begin
                if (line_bad || frame_bad) begin
                    lock_d = LK_UNLOCKED;
                    good_d = '0;
                end else if (vs_fall) begin
                    good_d = good_q + 4'd1;
                    if (good_q + 4'd1 >= LOCK_N)
                        lock_d = LK_LOCKED;
                end
            end
            LK_LOCKED: begin
                if (line_bad || frame_bad) begin
                    lock_d = LK_UNLOCKED;
                    good_d = '0;
                end
            end
            default: begin
                lock_d = LK_UNLOCKED;
                good_d = '0;
            end
        endcase
    end

    assign lock_state = lock_q;

endmodule

// File: rtl/vga_sync_capture.sv
// Captures a WIN_W x WIN_H window of one locked VGA frame into a write-only RAM port.
// Optional VGA_CAP_CHECKSUM_EN adds a 16-bit running sum of the written pixels.
module vga_sync_capture
    import vga_cap_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_START     = VGA_H_START,
    parameter int V_START     = VGA_V_START,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int WIN_W       = 120,
    parameter int WIN_H       = 160,
    parameter int ADDR_W      = 15,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [11:0]       rgb_in,
    input  logic [9:0]        win_x,
    input  logic [9:0]        win_y,
    input  logic              capture_req,
    output logic              locked,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [11:0]       wr_data,
    output logic              capture_done,
    output logic              capture_err
`ifdef VGA_CAP_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [10:0]       WIN_W11   = 11'(WIN_W);
    localparam logic [10:0]       WIN_H11   = 11'(WIN_H);
    localparam logic [10:0]       H_ACT11   = 11'(H_ACTIVE);
    localparam logic [10:0]       V_ACT11   = 11'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIN_W * WIN_H - 1);

    lock_state_t       lock_state;
    logic              vs_fall, px_active;
    logic [9:0]        px_x, px_y;
    logic [11:0]       px_data;

    cap_state_t        cap_q, cap_d;
    logic [9:0]        wx_q, wx_d, wy_q, wy_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [11:0]       wr_data_q, wr_data_d;
    logic              wr_en_q, wr_en_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              win_bad, in_win;

    vga_sync_meter #(
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .H_START    (H_START),
        .V_START    (V_START),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) u_meter (
        .pclk      (pclk),
        .rst       (rst),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .rgb_in    (rgb_in),
        .lock_state(lock_state),
        .vs_fall   (vs_fall),
        .active    (px_active),
        .x         (px_x),
        .y         (px_y),
        .pix       (px_data)
    );

    assign locked = (lock_state == LK_LOCKED);
    assign busy   = (cap_q == CAP_ARMED) || (cap_q == CAP_CAPTURE);

    assign win_bad = (({1'b0, win_x} + WIN_W11) > H_ACT11) ||
                     (({1'b0, win_y} + WIN_H11) > V_ACT11);
    assign in_win  = px_active &&
                     (px_x >= wx_q) && ({1'b0, px_x} < ({1'b0, wx_q} + WIN_W11)) &&
                     (px_y >= wy_q) && ({1'b0, px_y} < ({1'b0, wy_q} + WIN_H11));

    // Handshake: capture_req is a one-cycle request honoured only in IDLE; it answers with
    // either busy (armed) or a one-cycle capture_err. wr_en qualifies wr_addr/wr_data for
    // exactly one cycle with no back-pressure; capture_done follows the final write by one cycle.
    always_comb begin
        cap_d       = cap_q;
        wx_d        = wx_q;
        wy_d        = wy_q;
        next_addr_d = next_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        last_d      = 1'b0;
        done_d      = last_q;
        err_d       = 1'b0;
        case (cap_q)
            CAP_IDLE: begin
                if (capture_req) begin
                    if (!locked || win_bad) begin
                        err_d = 1'b1;
                    end else begin
                        wx_d  = win_x;
                        wy_d  = win_y;
                        cap_d = CAP_ARMED;
                    end
                end
            end
            CAP_ARMED: begin
                if (!locked) begin
                    err_d = 1'b1;
                    cap_d = CAP_IDLE;
                end else if (vs_fall) begin
                    cap_d       = CAP_CAPTURE;
                    next_addr_d = '0;
                end
            end
            CAP_CAPTURE: begin
                if (!locked) begin
                    err_d = 1'b1;
                    cap_d = CAP_IDLE;
                end else if (in_win) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = next_addr_q;
                    wr_data_d   = px_data;
                    next_addr_d = next_addr_q + ADDR_W'(1);
                    if (next_addr_q == LAST_ADDR) begin
                        last_d = 1'b1;
                        cap_d  = CAP_IDLE;
                    end
                end
            end
            default: cap_d = CAP_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cap_q       <= CAP_IDLE;
            wx_q        <= '0;
            wy_q        <= '0;
            next_addr_q <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cap_q       <= cap_d;
            wx_q        <= wx_d;
            wy_q        <= wy_d;
            next_addr_q <= next_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            last_q      <= last_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign capture_done = done_q;
    assign capture_err  = err_q;

`ifdef VGA_CAP_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Entry into CAPTURE never coincides with a write, so clear and add are exclusive.
    always_comb begin
        sum_d = sum_q;
        if (cap_q == CAP_ARMED && cap_d == CAP_CAPTURE)
            sum_d = '0;
        else if (wr_en_d)
            sum_d = sum_q + {4'b0, px_data};
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_vga_sync_capture.sv
// Directed bench for vga_sync_capture on a scaled-down raster (40x30 total, 24x20 active)
// so that many frames fit in a short run; window is 6x4 pixels.
module tb_vga_sync_capture;

    localparam int H_TOTAL     = 40;
    localparam int V_TOTAL     = 30;
    localparam int H_START     = 8;
    localparam int V_START     = 4;
    localparam int H_ACTIVE    = 24;
    localparam int V_ACTIVE    = 20;
    localparam int WIN_W       = 6;
    localparam int WIN_H       = 4;
    localparam int ADDR_W      = 5;
    localparam int LOCK_FRAMES = 2;
    localparam int N_WR        = WIN_W * WIN_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WR - 1);

    logic              pclk = 1'b0;
    logic              rst;
    logic              hsync_in, vsync_in, capture_req;
    logic [11:0]       rgb_in;
    logic [9:0]        win_x, win_y;
    logic              locked, busy, wr_en, capture_done, capture_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;
`ifdef VGA_CAP_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    logic [ADDR_W+11:0] exp_q[$];
    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int first_wr_cyc    = 0;
    int first_drive_cyc = 0;
    int exp_sum  = 0;
    logic const_mode = 1'b0;
    logic lk_p0, lk_p1, err_after, busy_after;

    vga_sync_capture #(
        .H_TOTAL    (H_TOTAL),
        .V_TOTAL    (V_TOTAL),
        .H_START    (H_START),
        .V_START    (V_START),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .WIN_W      (WIN_W),
        .WIN_H      (WIN_H),
        .ADDR_W     (ADDR_W),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .rgb_in      (rgb_in),
        .win_x       (win_x),
        .win_y       (win_y),
        .capture_req (capture_req),
        .locked      (locked),
        .busy        (busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .capture_done(capture_done),
        .capture_err (capture_err)
`ifdef VGA_CAP_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    // clock / cycle counter
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame of n_lines lines; line bad_line is one pclk short; optional capture_req at
    // line 1 / h 10; optional reset pulse at the start of rst_line.
    task automatic drive_frame(input int n_lines, input int bad_line, input int req_do,
                               input int rst_line);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            len = (l == bad_line) ? H_TOTAL - 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                logic [3:0] px, py;
                px = 4'(h - H_START);
                py = 4'(l - V_START);
                hsync_in    = (h < 4) ? 1'b0 : 1'b1;
                vsync_in    = (l < 2) ? 1'b0 : 1'b1;
                rgb_in      = const_mode ? 12'h001 : {px, py, 4'h5};
                capture_req = (req_do != 0) && (l == 1) && (h == 10);
                rst         = (l == rst_line) && (h < 2);
                if (l == V_START + int'(win_y) && h == H_START + int'(win_x))
                    first_drive_cyc = cyc;
                @(posedge pclk);
                #1;
                if (l == 0 && h == 0) lk_p0 = locked;
                if (l == 0 && h == 1) lk_p1 = locked;
                if (capture_req) begin
                    err_after  = capture_err;
                    busy_after = busy;
                end
            end
        end
        capture_req = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic push_window(input int rows);
        for (int j = 0; j < rows; j++) begin
            for (int i = 0; i < WIN_W; i++) begin
                logic [11:0]       d;
                logic [ADDR_W-1:0] a;
                a = ADDR_W'(j * WIN_W + i);
                d = const_mode ? 12'h001 : {4'(int'(win_x) + i), 4'(int'(win_y) + j), 4'h5};
                exp_q.push_back({a, d});
                exp_sum += int'(d);
            end
        end
    endtask

    // scoreboard / event monitor, sampled on the falling edge
    initial begin : monitor
        logic               prev_last;
        logic [ADDR_W+11:0] e;
        prev_last = 1'b0;
        forever begin
            @(negedge pclk);
            if (capture_done) begin
                done_cnt++;
                check("done_after_last_wr", {31'b0, prev_last}, 32'd1);
            end
            if (capture_err) err_cnt++;
            if (wr_en) begin
                wr_cnt++;
                if (wr_addr == '0) first_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("wr_expected", exp_q.size(), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr_data", {wr_addr, wr_data}, e);
                end
            end
            prev_last = wr_en && (wr_addr == LAST_ADDR);
        end
    end

    initial begin
        rst = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = '0;
        win_x = '0; win_y = '0; capture_req = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_done", capture_done, 0);
        check("rst_err", capture_err, 0);
`ifdef VGA_CAP_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst = 1'b0;
        @(posedge pclk);
        #1;

        // F1: request while unlocked is rejected
        win_x = 10; win_y = 8;
        drive_frame(V_TOTAL, -1, 1, -1);
        check("req_unlocked_err", err_after, 1);
        check("req_unlocked_busy", busy_after, 0);
        // F2: one good frame, still not locked
        drive_frame(V_TOTAL, -1, 0, -1);
        check("lock_after_1_good", lk_p1, 0);
        // F3: locks at its vsync; window overflowing right edge rejected
        win_x = 19; win_y = 8;
        drive_frame(V_TOTAL, -1, 1, -1);
        check("lock_before_edge", lk_p0, 0);
        check("lock_rise", lk_p1, 1);
        check("req_x_over_err", err_after, 1);
        check("req_x_over_busy", busy_after, 0);
        // F4: window overflowing bottom edge rejected
        win_x = 10; win_y = 17;
        drive_frame(V_TOTAL, -1, 1, -1);
        check("req_y_over_err", err_after, 1);
        check("still_locked", locked, 1);
        // F5: accepted request; F6: capture, with a request while busy
        win_x = 10; win_y = 8;
        drive_frame(V_TOTAL, -1, 1, -1);
        check("req_ok_err", err_after, 0);
        check("req_ok_busy", busy_after, 1);
        exp_sum = 0;
        push_window(WIN_H);
        drive_frame(V_TOTAL, -1, 1, -1);
        check("req_busy_no_err", err_after, 0);
        check("cap1_done_cnt", done_cnt, 1);
        check("cap1_wr_cnt", wr_cnt, N_WR);
        check("cap1_q_empty", exp_q.size(), 0);
        check("cap1_busy_after", busy, 0);
        check("latency_2", first_wr_cyc, first_drive_cyc + 2);
        check("err_cnt_3", err_cnt, 3);
`ifdef VGA_CAP_CHECKSUM_EN
        check("cap1_checksum", checksum, exp_sum & 32'hFFFF);
`endif
        // F7/F8: window touching bottom-right corner
        win_x = 18; win_y = 16;
        drive_frame(V_TOTAL, -1, 1, -1);
        check("req_corner_busy", busy_after, 1);
        push_window(WIN_H);
        drive_frame(V_TOTAL, -1, 0, -1);
        check("cap2_done_cnt", done_cnt, 2);
        check("cap2_wr_cnt", wr_cnt, 2 * N_WR);
        check("cap2_q_empty", exp_q.size(), 0);
        // F9/F10: constant pixel at origin window
        win_x = 0; win_y = 0;
        drive_frame(V_TOTAL, -1, 1, -1);
        const_mode = 1'b1;
        exp_sum = 0;
        push_window(WIN_H);
        drive_frame(V_TOTAL, -1, 0, -1);
        const_mode = 1'b0;
        check("cap3_done_cnt", done_cnt, 3);
        check("cap3_q_empty", exp_q.size(), 0);
`ifdef VGA_CAP_CHECKSUM_EN
        check("cap3_checksum", checksum, 32'h0018);
`endif
        // F11/F12: short line inside the window aborts after the first row
        win_x = 10; win_y = 8;
        drive_frame(V_TOTAL, -1, 1, -1);
        push_window(1);
        drive_frame(V_TOTAL, V_START + 8, 0, -1);
        check("abort_err_cnt", err_cnt, 4);
        check("abort_no_done", done_cnt, 3);
        check("abort_q_empty", exp_q.size(), 0);
        check("abort_busy", busy, 0);
        check("abort_unlocked", locked, 0);
        // F13-F15: relock; F15 is 36 lines long while armed
        drive_frame(V_TOTAL, -1, 0, -1);
        drive_frame(V_TOTAL, -1, 0, -1);
        check("relock_not_yet", lk_p1, 0);
        drive_frame(V_TOTAL + 6, -1, 1, -1);
        check("relock", lk_p1, 1);
        check("armed_busy", busy_after, 1);
        // F16: long frame detected at its vsync, armed capture dropped
        drive_frame(V_TOTAL, -1, 0, -1);
        check("long_frame_err_cnt", err_cnt, 5);
        check("long_frame_no_done", done_cnt, 3);
        check("long_frame_busy", busy, 0);
        check("long_frame_unlocked", locked, 0);
        // F17-F20: relock, arm, reset in the middle of the capture
        drive_frame(V_TOTAL, -1, 0, -1);
        drive_frame(V_TOTAL, -1, 0, -1);
        drive_frame(V_TOTAL, -1, 1, -1);
        check("rearm_busy", busy_after, 1);
        push_window(1);
        drive_frame(V_TOTAL, -1, 0, V_START + 9);
        check("rst_mid_no_done", done_cnt, 3);
        check("rst_mid_no_err", err_cnt, 5);
        check("rst_mid_q_empty", exp_q.size(), 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_locked", locked, 0);
        check("rst_mid_wr_addr", wr_addr, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
